// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main controller: sequences each instruction through fetch/decode/execute/memory/writeback.
// Define MC_BNE_EN to build the BNE state (op 000101); otherwise that opcode is treated as illegal.
module mc_ctrl_fsm #(
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       pc_en,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11,
`ifdef MC_BNE_EN
    BNE    = 4'd13,
`endif
    JUMP   = 4'd12
  } state_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       fetch;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       jump;
    logic       branch;
    logic       bne;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MC_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  state_t r_state;
  state_t w_next;
  ctrl_t  r_ctrl;
  logic   r_illegal;
  logic   w_illegal_next;
  logic   w_complete;

  assign w_complete = (MEM_HANDSHAKE == 0) || mem_ready;

  // Outputs are registered from the next state so they line up with r_state as a Moore decode.
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.fetch = 1'b1; end
      DECODE: c.alu_src_b = 2'b11;
      MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      MEMRD:  begin c.iord = 1'b1; c.mem_read = 1'b1; end
      MEMWB:  begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      MEMWR:  begin c.iord = 1'b1; c.mem_write = 1'b1; end
      EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      ALUWB:  begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      ADDIEX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      ADDIWB: c.reg_write = 1'b1;
      BRANCH: begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.branch = 1'b1; end
      JUMP:   begin c.pc_src = 2'b10; c.jump = 1'b1; end
`ifdef MC_BNE_EN
      BNE:    begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.bne = 1'b1; end
`endif
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    w_next         = FETCH;
    w_illegal_next = 1'b0;
    case (r_state)
      FETCH:  w_next = w_complete ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_RTYPE:     w_next = EXEC;
          OP_BEQ:       w_next = BRANCH;
          OP_ADDI:      w_next = ADDIEX;
          OP_J:         w_next = JUMP;
`ifdef MC_BNE_EN
          OP_BNE:       w_next = BNE;
`endif
          default:      w_illegal_next = 1'b1;
        endcase
      end
      MEMADR: w_next = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  w_next = w_complete ? MEMWB : MEMRD;
      MEMWR:  w_next = w_complete ? FETCH : MEMWR;
      EXEC:   w_next = ALUWB;
      ADDIEX: w_next = ADDIWB;
      default: w_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ctrl    <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_ctrl    <= decode(w_next);
      r_illegal <= w_illegal_next;
    end
  end

  assign alu_op     = r_ctrl.alu_op;
  assign alu_src_a  = r_ctrl.alu_src_a;
  assign alu_src_b  = r_ctrl.alu_src_b;
  assign pc_src     = r_ctrl.pc_src;
  assign iord       = r_ctrl.iord;
  assign mem_read   = r_ctrl.mem_read;
  assign mem_write  = r_ctrl.mem_write;
  assign ir_write   = r_ctrl.fetch & w_complete;
  assign reg_write  = r_ctrl.reg_write;
  assign reg_dst    = r_ctrl.reg_dst;
  assign mem_to_reg = r_ctrl.mem_to_reg;
  assign pc_en      = (r_ctrl.fetch & w_complete) | r_ctrl.jump
                    | (r_ctrl.branch & zero) | (r_ctrl.bne & ~zero);
  assign illegal_op = r_illegal;
  assign state_o    = r_state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized bench for mc_ctrl_fsm: each instruction is expanded into its expected phase list and
// every cycle's state and control outputs are compared against the per-state output table.
`timescale 1ns/1ps
module tb_mc_ctrl_fsm;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [1:0] alu_op, alu_src_b, pc_src;
  logic       alu_src_a, iord, mem_read, mem_write, ir_write, reg_write;
  logic       reg_dst, mem_to_reg, pc_en, illegal_op;
  logic [3:0] state_o;
  logic [15:0] dut_vec;

  mc_ctrl_fsm #(.MEM_HANDSHAKE(1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .pc_en(pc_en),
    .illegal_op(illegal_op), .state_o(state_o)
  );

  always #5 clk = ~clk;

  assign dut_vec = {alu_op, alu_src_a, alu_src_b, pc_src, iord, mem_read, mem_write,
                    ir_write, reg_write, reg_dst, mem_to_reg, pc_en, illegal_op};

`ifdef MC_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  bit ill_pending = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Control outputs each state must show; rdy = access complete, z = ALU zero flag.
  function automatic logic [15:0] expect_out(input int st, input bit rdy, input bit z, input bit ill);
    logic [1:0] aop, sb, ps;
    bit sa, io, mr, mw, irw, rw, rd, m2r, pce;
    aop = 2'd0; sb = 2'd0; ps = 2'd0;
    sa = 0; io = 0; mr = 0; mw = 0; irw = 0; rw = 0; rd = 0; m2r = 0; pce = 0;
    case (st)
      1:  begin mr = 1; sb = 2'b01; irw = rdy; pce = rdy; end
      2:  sb = 2'b11;
      3:  begin sa = 1; sb = 2'b10; end
      4:  begin io = 1; mr = 1; end
      5:  begin m2r = 1; rw = 1; end
      6:  begin io = 1; mw = 1; end
      7:  begin sa = 1; aop = 2'b10; end
      8:  begin rd = 1; rw = 1; end
      9:  begin sa = 1; aop = 2'b01; ps = 2'b01; pce = z; end
      10: begin sa = 1; sb = 2'b10; end
      11: rw = 1;
      12: begin ps = 2'b10; pce = 1; end
      13: begin sa = 1; aop = 2'b01; ps = 2'b01; pce = !z; end
      default: ;
    endcase
    return {aop, sa, sb, ps, io, mr, mw, irw, rw, rd, m2r, pce, ill};
  endfunction

  function automatic string kind_of(input logic [5:0] o);
    case (o)
      6'b100011: return "lw";
      6'b101011: return "sw";
      6'b000000: return "rtype";
      6'b000100: return "beq";
      6'b001000: return "addi";
      6'b000010: return "j";
      6'b000101: return BNE_EN ? "bne" : "illegal";
      default:   return "illegal";
    endcase
  endfunction

  // Hold reset for 'hold' cycles, then release and observe the IDLE cycle.
  task automatic reset_seq(input int hold);
    rst_n = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      mem_ready = 1'($urandom); zero = 1'($urandom);
      #1;
      check($sformatf("rst_state%0d", i), state_o, 0);
      check($sformatf("rst_outs%0d", i), dut_vec, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'($urandom); zero = 1'($urandom);
    #1;
    check("idle_state", state_o, 0);
    check("idle_outs", dut_vec, 0);
    ill_pending = 1'b0;
    $display("reset hold=%0d released", hold);
  endtask

  task automatic run_instr(input logic [5:0] opc, input bit z, input int wf, input int wr,
                           input int ww, input int abort_at);
    int ph_st[$];
    int ph_wait[$];
    string k;
    int ncyc;
    bit exp_ill;
    k = kind_of(opc);
    ncyc = 0;
    ph_st.push_back(1); ph_wait.push_back(wf);
    ph_st.push_back(2); ph_wait.push_back(0);
    case (k)
      "lw":    begin ph_st.push_back(3); ph_wait.push_back(0); ph_st.push_back(4); ph_wait.push_back(wr);
                     ph_st.push_back(5); ph_wait.push_back(0); end
      "sw":    begin ph_st.push_back(3); ph_wait.push_back(0); ph_st.push_back(6); ph_wait.push_back(ww); end
      "rtype": begin ph_st.push_back(7); ph_wait.push_back(0); ph_st.push_back(8); ph_wait.push_back(0); end
      "addi":  begin ph_st.push_back(10); ph_wait.push_back(0); ph_st.push_back(11); ph_wait.push_back(0); end
      "beq":   begin ph_st.push_back(9); ph_wait.push_back(0); end
      "j":     begin ph_st.push_back(12); ph_wait.push_back(0); end
      "bne":   begin ph_st.push_back(13); ph_wait.push_back(0); end
      default: ;
    endcase
    for (int p = 0; p < ph_st.size(); p++) begin
      for (int c = 0; c <= ph_wait[p]; c++) begin
        @(negedge clk);
        op = opc; zero = z;
        if (ph_st[p] == 1 || ph_st[p] == 4 || ph_st[p] == 6) mem_ready = (c == ph_wait[p]);
        else mem_ready = 1'($urandom);
        #1;
        exp_ill = ill_pending;
        ill_pending = 1'b0;
        check($sformatf("%s_state_s%0d_c%0d", k, ph_st[p], c), state_o, ph_st[p]);
        check($sformatf("%s_outs_s%0d_c%0d", k, ph_st[p], c), dut_vec,
              expect_out(ph_st[p], mem_ready, z, exp_ill));
        ncyc++;
        if (ph_st[p] == abort_at) begin
          #1 rst_n = 1'b0;
          #1;
          check($sformatf("%s_abort_state", k), state_o, 0);
          check($sformatf("%s_abort_outs", k), dut_vec, 0);
          $display("instr %s op=%b zero=%0d aborted by reset after %0d cycles", k, opc, z, ncyc);
          reset_seq(1);
          return;
        end
      end
      if (ph_st[p] == 2 && k == "illegal") ill_pending = 1'b1;
    end
    $display("instr %s op=%b zero=%0d cycles=%0d", k, opc, z, ncyc);
  endtask

  function automatic int rand_wait();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
  endfunction

  initial begin
    logic [5:0] ops [0:8];
    logic [5:0] ro;
    ops[0] = 6'b100011; ops[1] = 6'b101011; ops[2] = 6'b000000;
    ops[3] = 6'b000100; ops[4] = 6'b001000; ops[5] = 6'b000010;
    ops[6] = 6'b000101; ops[7] = 6'b111111; ops[8] = 6'b000000;

    reset_seq(3);
    run_instr(6'b100011, 1'b0, 0, 0, 0, -1);
    run_instr(6'b000100, 1'b1, 0, 0, 0, -1);
    run_instr(6'b000100, 1'b0, 0, 0, 0, -1);
    run_instr(6'b101011, 1'b0, 0, 0, 3, -1);
    run_instr(6'b111111, 1'b0, 0, 0, 0, -1);
    run_instr(6'b001000, 1'b0, 0, 0, 0, -1);
    run_instr(6'b000000, 1'b1, 0, 0, 0, 8);
    run_instr(6'b000010, 1'b0, 2, 0, 0, -1);
    run_instr(6'b000101, 1'b0, 0, 0, 0, -1);
    run_instr(6'b000101, 1'b1, 0, 0, 0, -1);
`ifdef MC_BNE_EN
    run_instr(6'b000101, 1'b0, 0, 0, 0, 13);
`endif

    for (int n = 0; n < 300; n++) begin
      ro = ops[$urandom_range(0, 8)];
      if (ro == 6'b111111 && $urandom_range(0, 1) == 1) ro = 6'($urandom);
      run_instr(ro, 1'($urandom), rand_wait(), rand_wait(), rand_wait(), -1);
    end
    run_instr(6'b000010, 1'b0, 0, 0, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
